// File: rtl/com_bus_arbiter.sv
// com_bus_arbiter: registered one-hot grants for a processor and a snoop channel.
// Define ARB_TIMEOUT_EN to force release after TIMEOUT_CYCLES of continuous hold.
module com_bus_arbiter #(
  parameter int NUM_PROC       = 8,
  parameter int NUM_SNOOP      = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PROC-1:0]  Com_Bus_Req_proc,
  output logic [NUM_PROC-1:0]  Com_Bus_Gnt_proc,
  input  logic [NUM_SNOOP-1:0] Com_Bus_Req_snoop,
  input  logic                 Mem_snoop_req,
  output logic [NUM_SNOOP-1:0] Com_Bus_Gnt_snoop,
  output logic                 Mem_snoop_gnt,
  output logic                 Com_Bus_Gnt_snoop_any,
  output logic                 Arb_timeout
);

  localparam int PW = $clog2(NUM_PROC);
  localparam int SW = $clog2(NUM_SNOOP);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e               p_st_q;
  state_e               s_st_q;
  logic [PW-1:0]        ptr_p_q;
  logic [SW-1:0]        ptr_s_q;
  logic [NUM_PROC-1:0]  gnt_p_q;
  logic [NUM_SNOOP-1:0] gnt_s_q;
  logic                 mem_gnt_q;

  logic [NUM_PROC-1:0]  pick_p;
  logic [PW-1:0]        win_p;
  logic [PW-1:0]        nxt_p;
  logic                 found_p;
  logic [NUM_SNOOP-1:0] pick_s;
  logic [SW-1:0]        win_s;
  logic [SW-1:0]        nxt_s;
  logic                 found_s;
  logic                 own_p;
  logic                 own_s;
  logic                 exp_p;
  logic                 exp_s;

  always_comb begin
    pick_p  = '0;
    win_p   = '0;
    found_p = 1'b0;
    for (int i = 0; i < NUM_PROC; i++) begin
      int s;
      s = int'(ptr_p_q) + i;
      if (s >= NUM_PROC) s = s - NUM_PROC;
      if (!found_p && Com_Bus_Req_proc[PW'(s)]) begin
        found_p = 1'b1;
        win_p   = PW'(s);
      end
    end
    if (found_p) pick_p[win_p] = 1'b1;
    nxt_p = (win_p == PW'(NUM_PROC-1)) ? '0 : win_p + 1'b1;
  end

  always_comb begin
    pick_s  = '0;
    win_s   = '0;
    found_s = 1'b0;
    for (int i = 0; i < NUM_SNOOP; i++) begin
      int s;
      s = int'(ptr_s_q) + i;
      if (s >= NUM_SNOOP) s = s - NUM_SNOOP;
      if (!found_s && Com_Bus_Req_snoop[SW'(s)]) begin
        found_s = 1'b1;
        win_s   = SW'(s);
      end
    end
    if (found_s) pick_s[win_s] = 1'b1;
    nxt_s = (win_s == SW'(NUM_SNOOP-1)) ? '0 : win_s + 1'b1;
  end

  assign own_p = |(Com_Bus_Req_proc & gnt_p_q);
  assign own_s = |(Com_Bus_Req_snoop & gnt_s_q)
               | (Mem_snoop_req & mem_gnt_q);

`ifdef ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ?
                      $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYCLES-1);

  logic [CW-1:0] cnt_p_q;
  logic [CW-1:0] cnt_s_q;
  logic [1:0]    tout_q;

  assign exp_p = (cnt_p_q == LIM);
  assign exp_s = (cnt_s_q == LIM);

  // Counters sit at zero in IDLE, so they start from zero on every new grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p_q <= '0;
      cnt_s_q <= '0;
      tout_q  <= '0;
    end else begin
      cnt_p_q <= (p_st_q == GRANT) ? cnt_p_q + 1'b1 : '0;
      cnt_s_q <= (s_st_q == GRANT) ? cnt_s_q + 1'b1 : '0;
      tout_q[0] <= (p_st_q == GRANT) & own_p & exp_p;
      tout_q[1] <= (s_st_q == GRANT) & own_s & exp_s;
    end
  end

  assign Arb_timeout = |tout_q;
`else
  assign exp_p = 1'b0;
  assign exp_s = 1'b0;
  assign Arb_timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_st_q  <= IDLE;
      ptr_p_q <= '0;
      gnt_p_q <= '0;
    end else begin
      unique case (p_st_q)
        IDLE: begin
          if (found_p) begin
            p_st_q  <= GRANT;
            gnt_p_q <= pick_p;
            ptr_p_q <= nxt_p;
          end
        end
        GRANT: begin
          if (!own_p || exp_p) begin
            p_st_q  <= IDLE;
            gnt_p_q <= '0;
          end
        end
      endcase
    end
  end

  // Memory only wins an empty cache field and leaves ptr_s untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_st_q    <= IDLE;
      ptr_s_q   <= '0;
      gnt_s_q   <= '0;
      mem_gnt_q <= 1'b0;
    end else begin
      unique case (s_st_q)
        IDLE: begin
          if (found_s) begin
            s_st_q  <= GRANT;
            gnt_s_q <= pick_s;
            ptr_s_q <= nxt_s;
          end else if (Mem_snoop_req) begin
            s_st_q    <= GRANT;
            mem_gnt_q <= 1'b1;
          end
        end
        GRANT: begin
          if (!own_s || exp_s) begin
            s_st_q    <= IDLE;
            gnt_s_q   <= '0;
            mem_gnt_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign Com_Bus_Gnt_proc      = gnt_p_q;
  assign Com_Bus_Gnt_snoop     = gnt_s_q;
  assign Mem_snoop_gnt         = mem_gnt_q;
  assign Com_Bus_Gnt_snoop_any = (|gnt_s_q) | mem_gnt_q;

endmodule

// File: tb/tb_com_bus_arbiter.sv
// tb_com_bus_arbiter: scoreboard bench with an owner/pointer reference model.
// Directed test-plan sequences followed by randomized request traffic.
module tb_com_bus_arbiter;

  localparam int NP = 8;
  localparam int NS = 4;
  localparam int TO = 4;
  localparam bit TO_EN =
`ifdef ARB_TIMEOUT_EN
    1'b1;
`else
    1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic [NP-1:0] Com_Bus_Req_proc;
  logic [NP-1:0] Com_Bus_Gnt_proc;
  logic [NS-1:0] Com_Bus_Req_snoop;
  logic          Mem_snoop_req;
  logic [NS-1:0] Com_Bus_Gnt_snoop;
  logic          Mem_snoop_gnt;
  logic          Com_Bus_Gnt_snoop_any;
  logic          Arb_timeout;

  com_bus_arbiter #(
    .NUM_PROC      (NP),
    .NUM_SNOOP     (NS),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .Com_Bus_Req_proc     (Com_Bus_Req_proc),
    .Com_Bus_Gnt_proc     (Com_Bus_Gnt_proc),
    .Com_Bus_Req_snoop    (Com_Bus_Req_snoop),
    .Mem_snoop_req        (Mem_snoop_req),
    .Com_Bus_Gnt_snoop    (Com_Bus_Gnt_snoop),
    .Mem_snoop_gnt        (Mem_snoop_gnt),
    .Com_Bus_Gnt_snoop_any(Com_Bus_Gnt_snoop_any),
    .Arb_timeout          (Arb_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [14:0] exp_q[$];

  // Reference model: owner index (-1 none, NS = memory), pointer, hold count
  int  po = -1, pp = 0, ph = 0;
  int  so = -1, sp = 0, sh = 0;
  bit  pto = 0, sto = 0;

  logic [NP-1:0] cur_p = '0;
  logic [NS-1:0] cur_s = '0;
  logic          cur_m = 1'b0;

  function automatic logic [14:0] dut_vec();
    return {Com_Bus_Gnt_proc, Com_Bus_Gnt_snoop, Mem_snoop_gnt,
            Com_Bus_Gnt_snoop_any, Arb_timeout};
  endfunction

  task automatic check(input string nm, input logic [14:0] got,
                       input logic [14:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h expected=%h (gp/gs/m/any/to)", nm, got, exp);
    end
  endtask

  task automatic model_edge();
    bit f;
    if (!rst_n) begin
      po = -1; pp = 0; ph = 0; pto = 0;
      so = -1; sp = 0; sh = 0; sto = 0;
      return;
    end
    pto = 0;
    sto = 0;
    if (po < 0) begin
      f = 0;
      for (int i = 0; i < NP; i++) begin
        int k;
        k = (pp + i) % NP;
        if (!f && Com_Bus_Req_proc[k]) begin
          f = 1; po = k; pp = (k + 1) % NP; ph = 0;
        end
      end
    end else if (!Com_Bus_Req_proc[po]) begin
      po = -1;
    end else if (TO_EN && ph == TO - 1) begin
      po = -1; pto = 1;
    end else begin
      ph++;
    end
    if (so < 0) begin
      f = 0;
      for (int i = 0; i < NS; i++) begin
        int k;
        k = (sp + i) % NS;
        if (!f && Com_Bus_Req_snoop[k]) begin
          f = 1; so = k; sp = (k + 1) % NS; sh = 0;
        end
      end
      if (!f && Mem_snoop_req) begin
        so = NS; sh = 0;
      end
    end else if (!((so == NS) ? Mem_snoop_req : Com_Bus_Req_snoop[so])) begin
      so = -1;
    end else if (TO_EN && sh == TO - 1) begin
      so = -1; sto = 1;
    end else begin
      sh++;
    end
  endtask

  function automatic logic [14:0] model_vec();
    logic [NP-1:0] gp;
    logic [NS-1:0] gs;
    gp = '0;
    gs = '0;
    if (po >= 0) gp[po] = 1'b1;
    if (so >= 0 && so < NS) gs[so] = 1'b1;
    return {gp, gs, (so == NS), (so >= 0), (pto | sto)};
  endfunction

  task automatic step();
    Com_Bus_Req_proc  = cur_p;
    Com_Bus_Req_snoop = cur_s;
    Mem_snoop_req     = cur_m;
    model_edge();
    exp_q.push_back(model_vec());
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [14:0] e;
      e = exp_q.pop_front();
      check($sformatf("cyc%0d", cyc), dut_vec(), e);
      cyc++;
    end
  end

  always @(negedge rst_n) begin
    #1;
    check("async_rst", dut_vec(), 15'h0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NP-1:0] m;
    rst_n = 1'b0;
    Com_Bus_Req_proc  = '0;
    Com_Bus_Req_snoop = '0;
    Mem_snoop_req     = 1'b0;
    cur_p = 8'hFF;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    for (int k = 0; k < 9; k++) begin
      step();
      m = '0;
      m[po] = 1'b1;
      cur_p = 8'hFF & ~m;
      step();
      cur_p = 8'hFF;
      step();
    end
    cur_p = '0;
    repeat (2) step();

    cur_p = 8'h40; step();
    cur_p = 8'h00; step();
    cur_p = 8'h81; repeat (2) step();
    cur_p = 8'h01; repeat (2) step();
    cur_p = 8'h00; repeat (2) step();

    cur_s = 4'b0100; cur_m = 1'b1; repeat (2) step();
    cur_s = 4'b0000; repeat (3) step();
    cur_m = 1'b0; repeat (2) step();

    cur_p = 8'h01; cur_s = 4'b0100; repeat (2) step();
    cur_p = 8'h00; cur_s = 4'b0000; repeat (2) step();

    cur_p = 8'h10; repeat (2) step();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (2) step();
    cur_p = 8'h00; repeat (2) step();

    cur_p = 8'h03; repeat (10) step();
    cur_p = 8'h00; repeat (3) step();

    for (int n = 0; n < 600; n++) begin
      for (int b = 0; b < NP; b++)
        if ($urandom_range(0, 5) == 0) cur_p[b] = ~cur_p[b];
      for (int b = 0; b < NS; b++)
        if ($urandom_range(0, 5) == 0) cur_s[b] = ~cur_s[b];
      if ($urandom_range(0, 4) == 0) cur_m = ~cur_m;
      if ($urandom_range(0, 149) == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
      step();
    end

    cur_p = '0; cur_s = '0; cur_m = 1'b0;
    repeat (3) step();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got=%0d expected=0 pending", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
